// File: rtl/quant_lane_fifo.sv
// N-lane buffered channel: Low lanes drain through a round-robin merged port with grant lock,
// High lanes drain only through their own per-lane ports.
module quant_lane_fifo #(
    parameter int LANES     = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int PUB_LANES = 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int LW = (PUB_LANES > 1) ? $clog2(PUB_LANES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [LANES-1:0]       in_ready,
    input  logic [LANES-1:0]       flush,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic [LANES-1:0]       out_ready,
    output logic                   pub_valid,
    output logic [WIDTH-1:0]       pub_data,
    output logic [LW-1:0]          pub_lane,
    input  logic                   pub_ready,
    output logic [LANES*CW-1:0]    lane_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int unsigned NPUB = PUB_LANES;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    logic [WIDTH-1:0] mem    [LANES][DEPTH];
    logic [PW-1:0]    wr_ptr [LANES];
    logic [PW-1:0]    rd_ptr [LANES];
    logic [CW-1:0]    count  [LANES];

    arb_state_t       state;
    logic [LW-1:0]    rr_ptr;
    logic [LW-1:0]    held;
    logic [LW-1:0]    grant_scan;
    logic [LW-1:0]    grant;
    logic [LW-1:0]    next_rr;
    logic             scan_hit;
    logic             sel_nonempty;
    logic             sel_flush;
    logic [WIDTH-1:0] sel_data;
    logic             accept;

    logic [LANES-1:0] nonempty;
    logic [LANES-1:0] push;
    logic [LANES-1:0] pop;

    // Low-lane out_ready bits have no function; Low lanes pop only via the merged port.
    logic unused_low_ready;
    assign unused_low_ready = ^out_ready[NPUB-1:0];

    always_comb begin
        nonempty = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            nonempty[i] = (count[i] != '0);
            in_ready[i] = (count[i] < CW'(DEPTH));
        end
    end

    // Circular scan from rr_ptr: first lanes at/after rr_ptr, then lanes before it.
    always_comb begin
        grant_scan = '0;
        scan_hit   = 1'b0;
        for (int unsigned j = 0; j < NPUB; j++) begin
            if (!scan_hit && nonempty[j] && (j >= 32'(rr_ptr))) begin
                scan_hit   = 1'b1;
                grant_scan = LW'(j);
            end
        end
        for (int unsigned j = 0; j < NPUB; j++) begin
            if (!scan_hit && nonempty[j] && (j < 32'(rr_ptr))) begin
                scan_hit   = 1'b1;
                grant_scan = LW'(j);
            end
        end
    end

    always_comb begin
        grant        = (state == LOCKED) ? held : grant_scan;
        sel_nonempty = 1'b0;
        sel_flush    = 1'b0;
        sel_data     = '0;
        for (int unsigned j = 0; j < NPUB; j++) begin
            if (32'(grant) == j) begin
                sel_nonempty = nonempty[j];
                sel_flush    = flush[j];
                sel_data     = mem[j][rd_ptr[j]];
            end
        end
        pub_valid = sel_nonempty;
        pub_data  = sel_nonempty ? sel_data : '0;
        pub_lane  = sel_nonempty ? grant : '0;
        // A flush of the granted lane cancels the accept: no pop, no rr advance.
        accept    = sel_nonempty && pub_ready && !sel_flush;
        next_rr   = (32'(grant) == NPUB - 1) ? '0 : grant + 1'b1;
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            push[i] = in_valid[i] & in_ready[i];
            if (i < NPUB) begin
                pop[i] = accept && (32'(grant) == i);
            end else begin
                pop[i] = nonempty[i] & out_ready[i];
            end
        end
    end

    always_comb begin
        out_valid  = '0;
        out_data   = '0;
        lane_count = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_count[i*CW +: CW] = count[i];
            if (i >= NPUB) begin
                out_valid[i] = nonempty[i];
                out_data[i*WIDTH +: WIDTH] = nonempty[i] ? mem[i][rd_ptr[i]] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (push[i] && !flush[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (flush[i]) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    count[i]  <= '0;
                end else begin
                    if (push[i]) begin
                        wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    end
                    if (pop[i]) begin
                        rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    end
                    if (push[i] && !pop[i]) begin
                        count[i] <= count[i] + 1'b1;
                    end else if (pop[i] && !push[i]) begin
                        count[i] <= count[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            held   <= '0;
        end else if (!sel_nonempty || sel_flush) begin
            state <= IDLE;
        end else if (pub_ready) begin
            state  <= IDLE;
            rr_ptr <= next_rr;
        end else begin
            state <= LOCKED;
            held  <= grant;
        end
    end

endmodule

// File: tb/tb_quant_lane_fifo.sv
// Checks quant_lane_fifo (PUB_LANES=2) against a queue-based reference model: directed scenarios
// followed by randomized traffic.
module tb_quant_lane_fifo;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NPUB  = 2;
    localparam int CW    = 3;

    logic                   clk;
    logic                   reset;
    logic [LANES-1:0]       in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic [LANES-1:0]       in_ready;
    logic [LANES-1:0]       flush;
    logic [LANES-1:0]       out_valid;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_ready;
    logic                   pub_valid;
    logic [WIDTH-1:0]       pub_data;
    logic [0:0]             pub_lane;
    logic                   pub_ready;
    logic [LANES*CW-1:0]    lane_count;

    quant_lane_fifo #(
        .LANES(LANES),
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .PUB_LANES(NPUB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .pub_valid(pub_valid),
        .pub_data(pub_data),
        .pub_lane(pub_lane),
        .pub_ready(pub_ready),
        .lane_count(lane_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq [LANES][$];
    bit m_locked;
    int m_held;
    int m_rr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_locked) return m_held;
        for (int k = 0; k < NPUB; k++) begin
            int l;
            l = (m_rr + k) % NPUB;
            if (mq[l].size() > 0) return l;
        end
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LANES; i++) mq[i].delete();
        m_locked = 0;
        m_held   = 0;
        m_rr     = 0;
    endtask

    task automatic check_outputs();
        int g;
        bit pv;
        logic [LANES-1:0]       e_ready;
        logic [LANES-1:0]       e_ovalid;
        logic [LANES*WIDTH-1:0] e_odata;
        logic [LANES*CW-1:0]    e_count;
        g  = model_grant();
        pv = mq[g].size() > 0;
        check("pub_valid", 32'(pub_valid), 32'(pv));
        check("pub_lane", 32'(pub_lane), pv ? g : 0);
        check("pub_data", 32'(pub_data), pv ? 32'(mq[g][0]) : 0);
        e_ready = '0; e_ovalid = '0; e_odata = '0; e_count = '0;
        for (int i = 0; i < LANES; i++) begin
            e_ready[i] = mq[i].size() < DEPTH;
            e_count[i*CW +: CW] = CW'(mq[i].size());
            if (i >= NPUB && mq[i].size() > 0) begin
                e_ovalid[i] = 1'b1;
                e_odata[i*WIDTH +: WIDTH] = mq[i][0];
            end
        end
        check("in_ready", 32'(in_ready), 32'(e_ready));
        check("out_valid", 32'(out_valid), 32'(e_ovalid));
        check("out_data", out_data, e_odata);
        check("lane_count", 32'(lane_count), 32'(e_count));
    endtask

    // Check current outputs, advance the model with the applied inputs, then clock the DUT.
    task automatic step();
        int g;
        bit pv;
        bit acc;
        check_outputs();
        g  = model_grant();
        pv = mq[g].size() > 0;
        if (reset) begin
            model_clear();
        end else begin
            acc = pv && pub_ready && !flush[g];
            for (int i = 0; i < LANES; i++) begin
                bit room;
                bit popit;
                room  = mq[i].size() < DEPTH;
                popit = (i >= NPUB) ? (mq[i].size() > 0 && out_ready[i]) : (acc && g == i);
                if (flush[i]) begin
                    mq[i].delete();
                end else begin
                    if (popit) void'(mq[i].pop_front());
                    if (in_valid[i] && room) mq[i].push_back(in_data[i*WIDTH +: WIDTH]);
                end
            end
            if (!pv || flush[g]) begin
                m_locked = 0;
            end else if (pub_ready) begin
                m_locked = 0;
                m_rr = (g + 1) % NPUB;
            end else begin
                m_locked = 1;
                m_held = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        flush     = '0;
        out_ready = '0;
        pub_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'hF);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_pub_valid", 32'(pub_valid), 0);

        // 1: push 0xA5 into High lane 3
        in_valid = 4'b1000;
        in_data[31:24] = 8'hA5;
        step();
        idle_inputs();
        check("t1_out_valid3", 32'(out_valid[3]), 1);
        check("t1_out_data3", 32'(out_data[31:24]), 32'hA5);
        check("t1_count3", 32'(lane_count[11:9]), 1);

        // 2: fifth push into lane 2 refused, FIFO order on pop
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            in_valid = 4'b0100;
            in_data[23:16] = 8'(k);
            if (k == 5) check("t2_full_ready", 32'(in_ready[2]), 0);
            step();
        end
        idle_inputs();
        out_ready = 4'b0100;
        for (int k = 1; k <= 4; k++) begin
            check("t2_pop_order", 32'(out_data[23:16]), k);
            step();
        end
        check("t2_empty", 32'(out_valid[2]), 0);

        // 3: round-robin alternation over Low lanes
        do_reset();
        in_valid = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            in_data[7:0]  = 8'h10 + 8'(k);
            in_data[15:8] = 8'h20 + 8'(k);
            step();
        end
        idle_inputs();
        pub_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t3_rr_lane", 32'(pub_lane), k % 2);
            step();
        end
        check("t3_drained", 32'(pub_valid), 0);

        // 4: locked grant on lane 1 survives a new arrival on lane 0
        do_reset();
        in_valid = 4'b0010;
        in_data[15:8] = 8'h11;
        step();
        idle_inputs();
        in_valid = 4'b0001;
        in_data[7:0] = 8'h22;
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            check("t4_locked_lane", 32'(pub_lane), 1);
            check("t4_locked_data", 32'(pub_data), 32'h11);
            step();
        end
        pub_ready = 1'b1;
        step();
        idle_inputs();
        check("t4_next_lane", 32'(pub_lane), 0);
        check("t4_next_data", 32'(pub_data), 32'h22);

        // 5: flush of the locked lane with a same-cycle push
        do_reset();
        in_valid = 4'b0010;
        in_data[15:8] = 8'h44;
        step();
        idle_inputs();
        in_valid = 4'b0001;
        in_data[7:0] = 8'h33;
        step();
        idle_inputs();
        check("t5_locked", 32'(pub_lane), 1);
        flush = 4'b0010;
        in_valid = 4'b0010;
        in_data[15:8] = 8'h55;
        pub_ready = 1'b1;
        step();
        idle_inputs();
        check("t5_count1", 32'(lane_count[5:3]), 0);
        check("t5_count0", 32'(lane_count[2:0]), 1);
        check("t5_pub_lane", 32'(pub_lane), 0);
        check("t5_pub_data", 32'(pub_data), 32'h33);

        // 6: reset with three entries in every lane
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b1111;
            in_data = $urandom();
            step();
        end
        idle_inputs();
        check("t6_full_counts", 32'(lane_count), 32'h6DB);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_counts", 32'(lane_count), 0);
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_pub_valid", 32'(pub_valid), 0);
        check("t6_in_ready", 32'(in_ready), 32'hF);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            in_valid  = 4'($urandom());
            in_data   = $urandom();
            out_ready = 4'($urandom());
            pub_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < LANES; i++) flush[i] = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
